// File: rtl/sdr_pkg.sv
// Shared SDR receive-path definitions: magnitude modes, saturating abs helper
// and the alpha-max-beta-min shift constants.
package sdr_pkg;

    localparam logic MODE_REAL_ABS = 1'b0;
    localparam logic MODE_IQ_MAG   = 1'b1;

    // mag ~= max + (min >> 2) + (min >> 3), i.e. alpha = 1, beta = 0.375
    localparam int AMBM_SHIFT_A = 2;
    localparam int AMBM_SHIFT_B = 3;

    // |x| for a w-bit value sign-extended to 64 bits; the most-negative value
    // saturates to the largest positive one.
    function automatic logic [63:0] sat_abs(input logic signed [63:0] x, input int w);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (x < -lim)
            return lim;
        return (x < 0) ? -x : x;
    endfunction

endpackage

// File: rtl/iq_abs_mag.sv
// Two-stage per-sample magnitude: saturating abs + clip detect, then either
// |I| or an alpha-max-beta-min estimate of |I+jQ|.
module iq_abs_mag
    import sdr_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     mode,
    input  logic signed [DATA_W-1:0] i,
    input  logic signed [DATA_W-1:0] q,
    input  logic                     sample_valid,
    output logic        [DATA_W-1:0] mag,
    output logic                     clip,
    output logic                     mag_valid
);

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = ~MOST_NEG;

    logic [DATA_W-1:0] abs_i, abs_q, mx, mn, mag_next;
    logic              clip_s1, valid_s1, clip_now;

    assign clip_now = (i == MOST_NEG) || (i == MOST_POS) || (q == MOST_NEG) || (q == MOST_POS);

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_s1 <= 1'b0;
            abs_i    <= '0;
            abs_q    <= '0;
            clip_s1  <= 1'b0;
        end else begin
            valid_s1 <= sample_valid & ~flush;
            abs_i    <= DATA_W'(sat_abs(64'(i), DATA_W));
            abs_q    <= DATA_W'(sat_abs(64'(q), DATA_W));
            clip_s1  <= clip_now;
        end
    end

    // Inputs are at most 2^(DATA_W-1)-1, so the 1.375x sum fits in DATA_W bits.
    always_comb begin
        mx = (abs_i >= abs_q) ? abs_i : abs_q;
        mn = (abs_i >= abs_q) ? abs_q : abs_i;
        mag_next = abs_i;
        if (mode == MODE_IQ_MAG)
            mag_next = mx + (mn >> AMBM_SHIFT_A) + (mn >> AMBM_SHIFT_B);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mag_valid <= 1'b0;
            mag       <= '0;
            clip      <= 1'b0;
        end else begin
            mag_valid <= valid_s1 & ~flush;
            mag       <= mag_next;
            clip      <= clip_s1;
        end
    end

endmodule

// File: rtl/iq_level_meter.sv
// I/Q level meter: per-sample magnitude, power-of-two window average,
// decaying peak hold and LED thermometer / clip / heartbeat outputs.
module iq_level_meter
    import sdr_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int AVG_LOG2    = 4,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [2*DATA_W-1:0]   data,
    input  logic                  data_ready,
    output logic [DATA_W-1:0]     avg,
    output logic                  avg_valid,
    output logic [DATA_W-1:0]     peak,
    output logic [DATA_W+1:0]     display_lines
);

    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic                mode_q, mode_chg;
    logic [DATA_W-1:0]   mag;
    logic                mag_clip, mag_valid;

    logic [ACC_W-1:0]    acc, sum_q;
    logic [AVG_LOG2-1:0] cnt;
    logic [DATA_W-1:0]   win_max, max_q, max_next, avg_next, therm;
    logic                win_clip, clip_q, done;

    assign mode_chg = mode ^ mode_q;

    always_ff @(posedge sys_clk) begin
        if (!reset) mode_q <= MODE_REAL_ABS;
        else        mode_q <= mode;
    end

    iq_abs_mag #(.DATA_W(DATA_W)) u_abs_mag (
        .clk          (sys_clk),
        .reset        (reset),
        .flush        (mode_chg),
        .mode         (mode_q),
        .i            (data[2*DATA_W-1:DATA_W]),
        .q            (data[DATA_W-1:0]),
        .sample_valid (data_ready),
        .mag          (mag),
        .clip         (mag_clip),
        .mag_valid    (mag_valid)
    );

    always_comb begin
        max_next = (mag > win_max) ? mag : win_max;
        avg_next = DATA_W'(sum_q >> AVG_LOG2);
        therm    = '0;
        for (int k = 0; k < DATA_W; k++)
            therm[k] = (avg_next >= (DATA_W'(1) << k));
    end

    // Window stage: the completing sample latches the totals for the output stage.
    always_ff @(posedge sys_clk) begin
        if (!reset || mode_chg) begin
            acc      <= '0;
            cnt      <= '0;
            win_max  <= '0;
            win_clip <= 1'b0;
            sum_q    <= '0;
            max_q    <= '0;
            clip_q   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (mag_valid) begin
                if (&cnt) begin
                    done     <= 1'b1;
                    sum_q    <= acc + ACC_W'(mag);
                    max_q    <= max_next;
                    clip_q   <= win_clip | mag_clip;
                    acc      <= '0;
                    cnt      <= '0;
                    win_max  <= '0;
                    win_clip <= 1'b0;
                end else begin
                    acc      <= acc + ACC_W'(mag);
                    cnt      <= cnt + 1'b1;
                    win_max  <= max_next;
                    win_clip <= win_clip | mag_clip;
                end
            end
        end
    end

    // Output stage; a mode change keeps avg/thermometer/heartbeat but drops peak and clip.
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            avg           <= '0;
            avg_valid     <= 1'b0;
            peak          <= '0;
            display_lines <= '0;
        end else if (mode_chg) begin
            avg_valid             <= 1'b0;
            peak                  <= '0;
            display_lines[DATA_W] <= 1'b0;
        end else begin
            avg_valid <= done;
            if (done) begin
                avg                         <= avg_next;
                display_lines[DATA_W-1:0]   <= therm;
                display_lines[DATA_W]       <= clip_q;
                display_lines[DATA_W+1]     <= ~display_lines[DATA_W+1];
                if (max_q > peak) peak <= max_q;
                else              peak <= peak - (peak >> DECAY_SHIFT);
            end
        end
    end

endmodule

// File: doc/iq_level_meter.md
# iq_level_meter

Parametrised I/Q level meter for the SDR receive path: accepts complex samples with a one-cycle `data_ready` strobe and computes per-sample magnitude. Magnitude is either |I| or an alpha-max-beta-min approximation of |I+jQ|. Magnitudes are averaged over a power-of-two window, and a decaying peak is held. The result drives an LED bar display, with clip and heartbeat indicators. It replaces the single-channel real-abs LED driver and sits between the sample source and the board LEDs.

## Interface
- `DATA_W`, 16: bits per I or Q component (signed two's complement)
- `AVG_LOG2`, 4: averaging window = 2^AVG_LOG2 samples (1..8)
- `DECAY_SHIFT`, 3: peak decay per window = peak >> DECAY_SHIFT
- `sys_clk`  in  1: single clock
- `reset`  in  1: synchronous, active-low reset
- `mode`  in  1: 0 = |I| only, 1 = approx |I+jQ|
- `data`  in  2*DATA_W: [2*DATA_W-1:DATA_W] = I, [DATA_W-1:0] = Q
- `data_ready`  in  1: one-cycle valid strobe, back-to-back allowed
- `avg`  out  DATA_W: window-average magnitude, unsigned
- `avg_valid`  out  1: one-cycle pulse when `avg`/`peak` update
- `peak`  out  DATA_W: decaying peak magnitude, unsigned
- `display_lines`  out  DATA_W+2: [DATA_W-1:0] thermometer, [DATA_W] clip, [DATA_W+1] heartbeat

## Operation
- Stage 1 (abs): |x| = x for x ≥ 0, else -x; the most-negative value saturates to 2^(DATA_W-1)-1. The clip flag is set for this sample if either component equals -2^(DATA_W-1) or 2^(DATA_W-1)-1.
- Stage 2 (magnitude): mode 0: mag = |I|. Mode 1: mx = max(|I|,|Q|), mn = min; mag = mx + (mn>>2) + (mn>>3).
  - The sum is computed in DATA_W bits unsigned and cannot overflow, since max 1.375·(2^(DATA_W-1)-1) < 2^DATA_W.
- Stage 3 (window):
  - acc (DATA_W+AVG_LOG2 bits) accumulates mag; a window counter counts samples; win_max tracks the maximum mag; win_clip ORs the clip flags.
  - On the 2^AVG_LOG2-th sample:
    - avg ← (acc+mag) >> AVG_LOG2.
    - Peak update: if win_max (including this sample) > peak, peak ← win_max; else peak ← peak − (peak >> DECAY_SHIFT).
    - display_lines[DATA_W] ← win_clip; display_lines[DATA_W+1] toggles.
    - acc, counter, win_max and win_clip are cleared.
    - avg_valid pulses.
- Thermometer: LED k (0..DATA_W-1) is lit iff avg ≥ 2^k. So avg = 0 lights none; avg = 1 lights LED 0; avg ≥ 2^(DATA_W-1) lights all. It is updated in the same cycle as `avg`.
- Mode change: `mode` is registered each cycle. A change versus the registered value does the following on the next edge:
  - flushes stage 1–2 valids;
  - clears acc, counter, win_max, win_clip and peak;
  - produces no avg_valid for the partial window.
  - `avg`, the thermometer and the heartbeat hold their last values; clip is cleared.
- Samples arriving in the cycle the mode change is detected are discarded.
- Samples are never dropped otherwise; there is no backpressure.

## Timing
- Reset (reset = 0 at an edge): every output is 0, including avg, avg_valid, peak and display_lines; all internal state is cleared and in-flight samples are dropped. Reset mid-window discards that window.
- Latency: for the sample completing a window, with data_ready sampled at edge t, `avg`, `peak`, `display_lines` and `avg_valid` = 1 are visible after edge t+3. avg_valid stays high for exactly one cycle.
- Throughput: one sample per clock. With continuous data_ready, avg_valid pulses every 2^AVG_LOG2 cycles.
- Counter wrap: the window counter runs 0..2^AVG_LOG2-1 and wraps to 0 in the completing cycle. There is no gap cycle.
- Peak decay floors at 0: when peak >> DECAY_SHIFT = 0, peak holds (no underflow).
- A win_max equal to peak counts as "not greater", so decay applies.

## Structure
- Shared package `sdr_pkg`:
  - `MODE_REAL_ABS = 1'b0`, `MODE_IQ_MAG = 1'b1`;
  - a saturating-abs function;
  - the alpha-max-beta-min shift constants (2, 3).
- Sub-module `iq_abs_mag`: stages 1–2, with inputs I, Q, valid and mode, and outputs mag, clip and valid, 2-cycle latency with flush input. Window, peak and display logic live in the top.

## Test plan
- Reset: hold reset = 0 for 3 cycles with data_ready = 1 → all outputs 0; release → no avg_valid until the first 16 samples are complete.
- Mode 0, DATA_W = 16, AVG_LOG2 = 4: 16 back-to-back samples with I = -1000, Q = 5 → avg = 1000, avg_valid one cycle after edge 3 past the 16th sample, thermometer LEDs 0..9 lit (0x03FF), peak = 1000.
- Mode 1: I = 3000, Q = -4000, ×16 → mag = 4000 + 750 + 375 = 5125, avg = 5125, peak = 5125, display_lines[15:0] = 0x1FFF.
- Clip and saturation: one sample with I = 0x8000, 15 with I = 0, mode 0 → avg = 32767>>4 = 2047, clip bit = 1. The next all-zero window → clip = 0, peak = 32767 − 4095 = 28672, heartbeat toggled twice.
- Peak decay to floor: a window of mag 7 then zero windows, DECAY_SHIFT = 3 → peak stays 7 (7>>3 = 0, holds); check there is no underflow.
- Mode change mid-window: toggle mode after 8 samples → no avg_valid, peak = 0, avg held. The next full 16-sample window produces a correct avg in the new mode.
